// File: rtl/traffic_light_sequencer_if.sv
// ---------------------------------------------------------------------------
// traffic_light_sequencer_if
//   Bundles the request inputs and the lamp/debug outputs of the traffic
//   light sequencer. clk and reset stay plain ports on the sequencer.
//
//   tick_enb     one-clk tick pulse from the clock-enable generator
//   side_car     side-street vehicle sensor (level)
//   ped_btn      pedestrian push button (already synchronized/debounced)
//   main_lights  {red,yellow,green} for the main street
//   side_lights  {red,yellow,green} for the side street
//   walk         pedestrian WALK lamp
//   dont_walk    pedestrian DON'T WALK lamp, always ~walk
//   ped_pending  latched pedestrian request
//   state_out    current state encoding (debug)
//
//   master: the environment (drives requests, watches lamps)
//   slave : the sequencer itself
// ---------------------------------------------------------------------------
interface traffic_light_sequencer_if;
  logic       tick_enb;
  logic       side_car;
  logic       ped_btn;
  logic [2:0] main_lights;
  logic [2:0] side_lights;
  logic       walk;
  logic       dont_walk;
  logic       ped_pending;
  logic [2:0] state_out;

  modport master (
    output tick_enb, side_car, ped_btn,
    input  main_lights, side_lights, walk, dont_walk, ped_pending, state_out
  );

  modport slave (
    input  tick_enb, side_car, ped_btn,
    output main_lights, side_lights, walk, dont_walk, ped_pending, state_out
  );
endinterface

// File: rtl/traffic_light_sequencer.sv
// ---------------------------------------------------------------------------
// traffic_light_sequencer
//   Moore FSM for a two-way intersection with a pedestrian crossing. Main
//   street rests green; after its minimum green it yields to a side-street
//   car or a pending pedestrian request. All phase timing is counted in
//   ticks of tick_enb; without a tick, state and timer hold.
//
//   clk    system clock
//   reset  active-low, synchronous reset
//   bus    traffic_light_sequencer_if.slave (requests in, lamps/debug out)
// ---------------------------------------------------------------------------
module traffic_light_sequencer #(
  parameter int unsigned MAIN_GREEN_TICKS = 10,
  parameter int unsigned YELLOW_TICKS     = 3,
  parameter int unsigned ALLRED_TICKS     = 1,
  parameter int unsigned SIDE_GREEN_TICKS = 6,
  parameter int unsigned WALK_TICKS       = 5,
  parameter int unsigned TIMER_BITS       = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  traffic_light_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_MAIN_GREEN  = 3'd0,
    S_MAIN_YELLOW = 3'd1,
    S_ALLRED_A    = 3'd2,
    S_SIDE_GREEN  = 3'd3,
    S_SIDE_YELLOW = 3'd4,
    S_ALLRED_B    = 3'd5,
    S_WALK        = 3'd6
  } state_e;

  typedef logic [TIMER_BITS-1:0] timer_t;

  // Last timer value of each phase: a phase of N ticks exits on timer == N-1.
  localparam timer_t MG_LAST = timer_t'(MAIN_GREEN_TICKS - 1);
  localparam timer_t Y_LAST  = timer_t'(YELLOW_TICKS - 1);
  localparam timer_t AR_LAST = timer_t'(ALLRED_TICKS - 1);
  localparam timer_t SG_LAST = timer_t'(SIDE_GREEN_TICKS - 1);
  localparam timer_t W_LAST  = timer_t'(WALK_TICKS - 1);

  state_e state_q, state_d;
  timer_t timer_q, timer_d;
  logic   ped_pending_q, ped_pending_d;

  logic   phase_done;
  logic   illegal;
  state_e exit_state;

  logic [2:0] main_lights;
  logic [2:0] side_lights;
  logic       walk;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_MAIN_GREEN;
      timer_q       <= '0;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  // Exit condition and successor of the current phase.
  // NOTE: every signal written in a combinational block gets a default first,
  // otherwise paths that skip an assignment infer a latch.
  always_comb begin
    phase_done = 1'b0;
    illegal    = 1'b0;
    exit_state = S_MAIN_GREEN;
    case (state_q)
      S_MAIN_GREEN: begin
        phase_done = (timer_q == MG_LAST) && (bus.side_car || ped_pending_q);
        exit_state = S_MAIN_YELLOW;
      end
      S_MAIN_YELLOW: begin
        phase_done = (timer_q == Y_LAST);
        exit_state = S_ALLRED_A;
      end
      S_ALLRED_A: begin
        phase_done = (timer_q == AR_LAST);
        // A waiting pedestrian beats a waiting side-street car.
        exit_state = ped_pending_q ? S_WALK : S_SIDE_GREEN;
      end
      S_SIDE_GREEN: begin
        phase_done = (timer_q == SG_LAST);
        exit_state = S_SIDE_YELLOW;
      end
      S_SIDE_YELLOW: begin
        phase_done = (timer_q == Y_LAST);
        exit_state = S_ALLRED_B;
      end
      S_ALLRED_B: begin
        phase_done = (timer_q == AR_LAST);
        exit_state = S_MAIN_GREEN;
      end
      S_WALK: begin
        phase_done = (timer_q == W_LAST);
        exit_state = S_ALLRED_B;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    // Presses are latched in any state except WALK, tick or no tick.
    ped_pending_d = ped_pending_q | (bus.ped_btn && (state_q != S_WALK));

    if (illegal) begin
      // Recover from the unused encoding without waiting for a tick.
      state_d = S_MAIN_GREEN;
      timer_d = '0;
    end else if (bus.tick_enb) begin
      if (phase_done) begin
        state_d = exit_state;
        timer_d = '0;
      end else if (!((state_q == S_MAIN_GREEN) && (timer_q == MG_LAST))) begin
        // Main green saturates at its minimum while no request is waiting.
        timer_d = timer_q + 1'b1;
      end
    end

    // Entering WALK serves the request; this clear overrides a new press.
    if ((state_d == S_WALK) && (state_q != S_WALK)) begin
      ped_pending_d = 1'b0;
    end
  end

  // Lamp decode depends on the state register only.
  always_comb begin
    main_lights = 3'b100;
    side_lights = 3'b100;
    walk        = 1'b0;
    case (state_q)
      S_MAIN_GREEN:  main_lights = 3'b001;
      S_MAIN_YELLOW: main_lights = 3'b010;
      S_SIDE_GREEN:  side_lights = 3'b001;
      S_SIDE_YELLOW: side_lights = 3'b010;
      S_WALK:        walk        = 1'b1;
      default: ;
    endcase
  end

  assign bus.main_lights = main_lights;
  assign bus.side_lights = side_lights;
  assign bus.walk        = walk;
  assign bus.dont_walk   = ~walk;
  assign bus.ped_pending = ped_pending_q;
  assign bus.state_out   = state_q;

endmodule
